// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard scoreboard.
package hazard_pkg;

  typedef enum logic [1:0] {
    OPC_ALU  = 2'd0,
    OPC_LOAD = 2'd1,
    OPC_LONG = 2'd2,
    OPC_RSVD = 2'd3
  } opc_e;

  localparam int DEF_NREG     = 32;
  localparam int DEF_LOAD_LAT = 2;
  localparam int DEF_LONG_LAT = 4;

  // Bits needed to hold any value 0..max(a,b).
  function automatic int clog2_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/id_hazard_scoreboard_sb_counter.sv
// One scoreboard entry: CW-bit countdown that saturates at zero; a set wins over the decrement.
module sb_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          set,
  input  logic [CW-1:0] set_val,
  output logic [CW-1:0] cnt,
  output logic          nz
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (set) begin
      cnt <= set_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign nz = (cnt != '0);

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode-stage RAW/WAW hazard scoreboard driving IF/ID and ID/EX controls.
// Optional stall/redirect statistics outputs are enabled by defining HAZARD_STATS_EN.
module id_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG     = DEF_NREG,
  parameter int AW       = $clog2(NREG),
  parameter int LOAD_LAT = DEF_LOAD_LAT,
  parameter int LONG_LAT = DEF_LONG_LAT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic            rs1_used,
  input  logic            rs2_used,
  input  logic [AW-1:0]   rd_addr,
  input  logic            rd_wen,
  input  logic [1:0]      op_class,
  input  logic            redirect,
  output logic            stall,
  output logic            if_write,
  output logic            id_ex_bubble,
  output logic            if_id_flush,
  output logic            issue,
  output logic [NREG-1:0] busy_mask
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     redirect_count
`endif
);

  localparam int CW = clog2_max(LOAD_LAT, LONG_LAT);

  logic [CW-1:0] cnt [NREG];
  logic [CW-1:0] nl;
  logic          raw;
  logic          waw;
  logic          set_en;

  assign cnt[0]       = '0;
  assign busy_mask[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    sb_counter #(.CW(CW)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .set     (set_en && (rd_addr == AW'(i))),
      .set_val (nl),
      .cnt     (cnt[i]),
      .nz      (busy_mask[i])
    );
  end

  // Reserved op class behaves like a single-cycle ALU op.
  always_comb begin
    nl = '0;
    case (opc_e'(op_class))
      OPC_LOAD: nl = CW'(LOAD_LAT - 1);
      OPC_LONG: nl = CW'(LONG_LAT - 1);
      default:  nl = '0;
    endcase
  end

  assign raw = id_valid &
               ((rs1_used && rs1_addr != '0 && cnt[rs1_addr] != '0) ||
                (rs2_used && rs2_addr != '0 && cnt[rs2_addr] != '0));

  // An older, slower write to the same rd must land before ours.
  assign waw = id_valid & rd_wen & (rd_addr != '0) & (cnt[rd_addr] > nl);

  assign stall        = raw | waw;
  assign if_write     = ~stall;
  assign id_ex_bubble = stall;
  assign issue        = id_valid & ~stall;
  assign if_id_flush  = redirect & issue;
  assign set_en       = issue & rd_wen & (rd_addr != '0);

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + 32'd1;
      if (if_id_flush && redirect_count != '1)
        redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule
